// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic unit.
//   OP_*  : op-select codes on the op port
//   state_t : controller states (idle, multiply iterating, divide iterating)
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/arith_addsub.sv
// Combinational unsigned add/subtract with carry/borrow out.
//   a, b : W-bit operands
//   sub  : 0 = a+b, 1 = a-b
//   s    : (W+1)-bit result; s[W] is carry (add) or borrow (sub)
module arith_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W:0]   s
);

  always_comb begin
    if (sub) s = {1'b0, a} - {1'b0, b};
    else     s = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/seq_arith_unit.sv
// N-bit unsigned arithmetic engine with start/done handshake.
//   clk, rst_n : clock, async active-low reset
//   start, op  : request and operation (add/sub/mul/div), sampled in idle only
//   x, y       : operands, captured on the accepting edge
//   busy       : high while mul/div iterate (N cycles)
//   done       : one-cycle pulse when result/flag are updated
//   result     : 2N-bit result, held until the next completion
//   flag       : carry / borrow / mul overflow / div-by-zero
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           flag
);

  localparam int CW = $clog2(N) + 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  // Mul: {partial high, multiplier shifting out}. Div: {remainder, dividend/quotient}.
  logic [2*N-1:0]   acc;
  logic [N-1:0]     opnd;   // multiplicand or divisor

  logic [N:0]       as_a, as_b;
  logic             as_sub;
  logic [N+1:0]     as_s;

  // One (N+1)-bit adder serves all ops; its inputs are steered by state.
  always_comb begin
    as_a   = {1'b0, x};
    as_b   = {1'b0, y};
    as_sub = (op == OP_SUB);
    case (state)
      S_MUL: begin
        as_a   = {1'b0, acc[2*N-1:N]};
        as_b   = acc[0] ? {1'b0, opnd} : '0;
        as_sub = 1'b0;
      end
      S_DIV: begin
        // trial subtract of divisor from remainder shifted with next dividend bit
        as_a   = {acc[2*N-1:N], acc[N-1]};
        as_b   = {1'b0, opnd};
        as_sub = 1'b1;
      end
      default: ;
    endcase
  end

  arith_addsub #(.W(N+1)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .s   (as_s)
  );

  logic [2*N-1:0] mul_next, div_next;
  logic           div_borrow;
  logic [N-1:0]   div_rem;
  logic           last;

  assign mul_next   = {as_s[N:0], acc[N-1:1]};
  assign div_borrow = as_s[N+1];
  // on borrow, restore: shifted remainder is below the divisor so fits N bits
  assign div_rem    = div_borrow ? as_a[N-1:0] : as_s[N-1:0];
  assign div_next   = {div_rem, acc[N-2:0], ~div_borrow};
  assign last       = (cnt == CW'(N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flag   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_ADD: begin
                result      <= '0;
                result[N:0] <= as_s[N:0];
                flag        <= as_s[N];
                done        <= 1'b1;
              end
              OP_SUB: begin
                result        <= '0;
                result[N-1:0] <= as_s[N-1:0];
                flag          <= as_s[N+1];
                done          <= 1'b1;
              end
              OP_MUL: begin
                state <= S_MUL;
                busy  <= 1'b1;
                acc   <= {{N{1'b0}}, y};
                opnd  <= x;
                cnt   <= '0;
              end
              default: begin
                if (y == '0) begin
                  result <= {x, {N{1'b1}}};
                  flag   <= 1'b1;
                  done   <= 1'b1;
                end else begin
                  state <= S_DIV;
                  busy  <= 1'b1;
                  acc   <= {{N{1'b0}}, x};
                  opnd  <= y;
                  cnt   <= '0;
                end
              end
            endcase
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= mul_next;
            flag   <= |mul_next[2*N-1:N];
            cnt    <= '0;
          end
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= div_next;
            flag   <= 1'b0;
            cnt    <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
module tb_seq_arith_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic       start4 = 1'b0;
  logic [1:0] op4 = 2'b00;
  logic [3:0] x4 = '0, y4 = '0;
  logic       busy4, done4, flag4;
  logic [7:0] result4;

  // N=8 instance
  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        busy8, done8, flag8;
  logic [15:0] result8;

  int tests = 0;
  int errors = 0;

  seq_arith_unit #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .result(result4), .flag(flag4)
  );

  seq_arith_unit #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .result(result8), .flag(flag8)
  );

  // Issue one op on dut4; returns number of edges after the accepting edge
  // until done is seen (0 for single-cycle ops), 99 on timeout.
  task automatic run4(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                      output int lat);
    @(negedge clk);
    op4 = o; x4 = a; y4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done4) lat = 99;
  endtask

  task automatic test_reset();
    tests++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
    tests++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done4); end
    tests++; if (result4 !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result4); end
    tests++; if (flag4 !== 1'b0) begin errors++; $display("FAIL reset_flag got %b want 0", flag4); end
    tests++; if (result8 !== 16'h0000 || done8 !== 1'b0) begin errors++; $display("FAIL reset_n8 got %h/%b want 0000/0", result8, done8); end
  endtask

  task automatic test_add();
    int lat;
    run4(2'b00, 4'd9, 4'd9, lat);
    tests++; if (lat !== 0) begin errors++; $display("FAIL add_latency got %0d want 0", lat); end
    tests++; if (result4 !== 8'h12) begin errors++; $display("FAIL add_result got %h want 12", result4); end
    tests++; if (flag4 !== 1'b1) begin errors++; $display("FAIL add_carry got %b want 1", flag4); end
    tests++; if (busy4 !== 1'b0) begin errors++; $display("FAIL add_busy got %b want 0", busy4); end
    run4(2'b00, 4'd3, 4'd4, lat);
    tests++; if (result4 !== 8'h07 || flag4 !== 1'b0) begin errors++; $display("FAIL add_nocarry got %h/%b want 07/0", result4, flag4); end
  endtask

  task automatic test_sub();
    int lat;
    run4(2'b01, 4'd3, 4'd5, lat);
    tests++; if (lat !== 0) begin errors++; $display("FAIL sub_latency got %0d want 0", lat); end
    tests++; if (result4 !== 8'h0E || flag4 !== 1'b1) begin errors++; $display("FAIL sub_borrow got %h/%b want 0E/1", result4, flag4); end
    run4(2'b01, 4'd5, 4'd3, lat);
    tests++; if (result4 !== 8'h02 || flag4 !== 1'b0) begin errors++; $display("FAIL sub_noborrow got %h/%b want 02/0", result4, flag4); end
  endtask

  task automatic test_mul();
    int lat;
    int held_bad;
    @(negedge clk);
    op4 = 2'b10; x4 = 4'd15; y4 = 4'd15; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    held_bad = 0;
    lat = 0;
    // scramble inputs while iterating; result must hold the previous value (02)
    while (!done4 && lat < 40) begin
      if (busy4 !== 1'b1 || result4 !== 8'h02) held_bad++;
      x4 = 4'd1; y4 = 4'd2; op4 = 2'b00;
      @(negedge clk);
      lat++;
    end
    tests++; if (lat !== 4) begin errors++; $display("FAIL mul_latency got %0d want 4", lat); end
    tests++; if (held_bad !== 0) begin errors++; $display("FAIL mul_busy_hold got %0d bad cycles want 0", held_bad); end
    tests++; if (result4 !== 8'hE1 || flag4 !== 1'b1) begin errors++; $display("FAIL mul_15x15 got %h/%b want E1/1", result4, flag4); end
    tests++; if (busy4 !== 1'b0) begin errors++; $display("FAIL mul_busy_done got %b want 0", busy4); end
    @(negedge clk);
    tests++; if (done4 !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got %b want 0", done4); end
    run4(2'b10, 4'd3, 4'd5, lat);
    tests++; if (result4 !== 8'h0F || flag4 !== 1'b0) begin errors++; $display("FAIL mul_3x5 got %h/%b want 0F/0", result4, flag4); end
    run4(2'b10, 4'd6, 4'd11, lat);
    tests++; if (result4 !== 8'h42 || flag4 !== 1'b1) begin errors++; $display("FAIL mul_6x11 got %h/%b want 42/1", result4, flag4); end
  endtask

  task automatic test_div();
    int lat;
    run4(2'b11, 4'd13, 4'd4, lat);
    tests++; if (lat !== 4) begin errors++; $display("FAIL div_latency got %0d want 4", lat); end
    tests++; if (result4 !== 8'h13 || flag4 !== 1'b0) begin errors++; $display("FAIL div_13_4 got %h/%b want 13/0", result4, flag4); end
    run4(2'b11, 4'd15, 4'd2, lat);
    tests++; if (result4 !== 8'h17 || flag4 !== 1'b0) begin errors++; $display("FAIL div_15_2 got %h/%b want 17/0", result4, flag4); end
    run4(2'b11, 4'd7, 4'd0, lat);
    tests++; if (lat !== 0) begin errors++; $display("FAIL divz_latency got %0d want 0", lat); end
    tests++; if (result4 !== 8'h7F || flag4 !== 1'b1) begin errors++; $display("FAIL divz_result got %h/%b want 7F/1", result4, flag4); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int lat;
    // start pulsed mid-multiply must be dropped
    @(negedge clk);
    op4 = 2'b10; x4 = 4'd2; y4 = 4'd3; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin op4 = 2'b00; x4 = 4'd1; y4 = 4'd1; start4 = 1'b1; end
      if (i == 2) start4 = 1'b0;
      if (done4 === 1'b1) ndone++;
      if (done4 === 1'b1 && busy4 === 1'b1) ndone += 100;
      @(negedge clk);
    end
    tests++; if (ndone !== 1) begin errors++; $display("FAIL start_while_busy got %0d dones want 1", ndone); end
    tests++; if (result4 !== 8'h06) begin errors++; $display("FAIL start_while_busy_result got %h want 06", result4); end
    // start presented during the done cycle is accepted
    run4(2'b10, 4'd2, 4'd2, lat);
    op4 = 2'b00; x4 = 4'd1; y4 = 4'd2; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    tests++; if (done4 !== 1'b1 || result4 !== 8'h03 || busy4 !== 1'b0) begin
      errors++; $display("FAIL start_in_done got done=%b res=%h busy=%b want 1/03/0", done4, result4, busy4);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    op4 = 2'b10; x4 = 4'd15; y4 = 4'd15; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy4 !== 1'b0 || done4 !== 1'b0 || result4 !== 8'h00 || flag4 !== 1'b0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b res=%h flag=%b want 0/0/00/0", busy4, done4, result4, flag4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) ndone++;
    end
    tests++; if (ndone !== 0) begin errors++; $display("FAIL reset_mid_nodone got %0d want 0", ndone); end
  endtask

  task automatic test_div8();
    int lat;
    @(negedge clk);
    op8 = 2'b11; x8 = 8'd200; y8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    tests++; if (lat !== 8) begin errors++; $display("FAIL div8_latency got %0d want 8", lat); end
    tests++; if (result8 !== 16'h041C || flag8 !== 1'b0) begin errors++; $display("FAIL div8_200_7 got %h/%b want 041C/0", result8, flag8); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid();
    test_div8();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
